// File: rtl/hls_deadlock_report_ctrl.sv
// Central deadlock report controller: confirms a persistent detection, launches
// one token from the lowest detecting process, follows it and latches the cycle.
module hls_deadlock_report_ctrl #(
  parameter int PROC_NUM       = 4,
  parameter int ID_W           = 2,
  parameter int CONFIRM_CYCLES = 8,
  parameter int WALK_TIMEOUT   = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PROC_NUM-1:0] dl_detect_vec,
  input  logic [PROC_NUM-1:0] token_active_vec,
  input  logic                report_ack,
  output logic                dl_detect_in,
  output logic [PROC_NUM-1:0] origin_vec,
  output logic                token_clear,
  output logic                report_vld,
  output logic [ID_W-1:0]     report_origin_id,
  output logic [PROC_NUM-1:0] report_proc_mask,
  output logic [ID_W:0]       report_len,
  output logic                report_timeout
);

  localparam int LW = ID_W + 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONFIRM = 3'd1;
  localparam logic [2:0] S_ORIGIN  = 3'd2;
  localparam logic [2:0] S_WALK    = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;

  logic [2:0]          state;
  logic [ID_W-1:0]     cand;
  logic [7:0]          cnt;
  logic [15:0]         wcnt;
  logic [PROC_NUM-1:0] mask;
  logic [PROC_NUM-1:0] mask_nxt;
  logic [ID_W-1:0]     low_idx;
  logic                cand_hit;
  logic                walk_ret;
  logic                walk_to;

  function automatic logic [LW-1:0] popcnt(input logic [PROC_NUM-1:0] v);
    logic [LW-1:0] s;
    s = '0;
    for (int i = 0; i < PROC_NUM; i++) s = s + LW'(v[i]);
    return s;
  endfunction

  // Descending scan so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--)
      if (dl_detect_vec[i]) low_idx = ID_W'(i);
  end

  assign cand_hit = dl_detect_vec[cand];
  assign mask_nxt = mask | token_active_vec;
  assign walk_ret = (state == S_WALK) && cand_hit;
  assign walk_to  = (state == S_WALK) && (wcnt == 16'(WALK_TIMEOUT - 1));

  // Gated by reset so the units never see a clear while the controller is held.
  assign token_clear = reset && (walk_ret || walk_to);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state            <= S_IDLE;
      cand             <= '0;
      cnt              <= '0;
      wcnt             <= '0;
      mask             <= '0;
      dl_detect_in     <= 1'b0;
      origin_vec       <= '0;
      report_vld       <= 1'b0;
      report_origin_id <= '0;
      report_proc_mask <= '0;
      report_len       <= '0;
      report_timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|dl_detect_vec) begin
            cand  <= low_idx;
            cnt   <= 8'd1;
            state <= S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (!cand_hit) begin
            state <= S_IDLE;
          end else if (cnt == 8'(CONFIRM_CYCLES - 1)) begin
            state        <= S_ORIGIN;
            origin_vec   <= PROC_NUM'(1) << cand;
            dl_detect_in <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_ORIGIN: begin
          origin_vec <= '0;
          mask       <= PROC_NUM'(1) << cand;
          wcnt       <= '0;
          state      <= S_WALK;
        end
        S_WALK: begin
          mask <= mask_nxt;
          if (walk_ret || walk_to) begin
            state            <= S_REPORT;
            report_vld       <= 1'b1;
            report_origin_id <= cand;
            report_proc_mask <= mask_nxt;
            report_len       <= popcnt(mask_nxt);
            report_timeout   <= !walk_ret;
          end else begin
            wcnt <= wcnt + 16'd1;
          end
        end
        S_REPORT: begin
          if (report_ack) begin
            state            <= S_IDLE;
            dl_detect_in     <= 1'b0;
            report_vld       <= 1'b0;
            report_origin_id <= '0;
            report_proc_mask <= '0;
            report_len       <= '0;
            report_timeout   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hls_deadlock_report_ctrl.md
# hls_deadlock_report_ctrl

Central controller downstream of the per-process deadlock detection units of the HLS dataflow monitor. It collects every unit's `dl_detect_out` and confirms a persistent detection. It then launches a single report token from the chosen origin process, follows the token around the dependency cycle, and latches a report of the processes involved. The broadcast `dl_detect_in`, one-hot `origin`, and `token_clear` outputs drive the detection units directly.

## Interface
- `PROC_NUM`, 4, number of dataflow processes (one detection unit each).
- `ID_W`, 2, width of a process index; must be ≥ clog2(`PROC_NUM`).
- `CONFIRM_CYCLES`, 8, consecutive cycles a detection must hold before reporting; legal range 2..255.
- `WALK_TIMEOUT`, 64, maximum WALK cycles before abort; legal range 2..65535.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `dl_detect_vec` in `PROC_NUM`: bit i = `dl_detect_out` of unit i.
- `token_active_vec` in `PROC_NUM`: bit i = OR of unit i's `token_out_vec`.
- `report_ack` in 1: consumer accepts the report.
- `dl_detect_in` out 1: registered broadcast to all units; reset 0.
- `origin_vec` out `PROC_NUM`: registered one-hot; bit i drives `origin` of unit i; reset 0.
- `token_clear` out 1: combinational broadcast to all units; 0 while in reset.
- `report_vld` out 1: registered; reset 0.
- `report_origin_id` out `ID_W`: registered; reset 0.
- `report_proc_mask` out `PROC_NUM`: registered; reset 0.
- `report_len` out `ID_W`+1: registered popcount of the mask; reset 0.
- `report_timeout` out 1: registered; reset 0.

## Operation
- States: IDLE, CONFIRM, ORIGIN, WALK, REPORT. Reset state is IDLE.
- All outputs return to their reset values on the first rising edge that samples `reset`=0, from any state.
- **IDLE**
  - All outputs 0.
  - If `dl_detect_vec` ≠ 0: `cand` ← index of the lowest set bit, `cnt` ← 1, go to CONFIRM.
- **CONFIRM**
  - If `dl_detect_vec[cand]` = 0: go to IDLE. The candidate is dropped and no other bit is considered this cycle.
  - Otherwise, if `cnt` = `CONFIRM_CYCLES`−1: go to ORIGIN.
  - Otherwise: `cnt`++.
- **ORIGIN** (lasts exactly 1 cycle)
  - `origin_vec` = 1<<`cand`.
  - `dl_detect_in` = 1.
  - `mask` ← 1<<`cand`, `wcnt` ← 0.
  - Go to WALK.
- **WALK**
  - `dl_detect_in` = 1, `origin_vec` = 0.
  - Every cycle: `mask` ← `mask` | `token_active_vec`.
  - Return: if `dl_detect_vec[cand]` = 1, then `token_clear` = 1 in that same cycle and the next state is REPORT with `report_timeout` = 0.
  - Timeout: else if `wcnt` = `WALK_TIMEOUT`−1, then `token_clear` = 1 and the next state is REPORT with `report_timeout` = 1.
  - Otherwise: `wcnt`++.
  - Return takes precedence over timeout when both occur in the same cycle.
  - `dl_detect_vec` bits other than `cand` are ignored.
- **REPORT**
  - `report_vld` = 1.
  - Fields loaded on entry and held stable: `report_origin_id` = `cand`, `report_proc_mask` = final `mask` (includes the last WALK cycle's `token_active_vec`), `report_len` = popcount of that mask.
  - `dl_detect_in` stays 1 to freeze the units.
  - `report_ack` = 1 → IDLE; all report outputs and `dl_detect_in` are 0 in the next cycle.
- `report_ack` outside REPORT is ignored.

## Timing
- Detection is first seen in IDLE at cycle t0 and held continuously.
- `origin_vec` and `dl_detect_in` are high in cycle t0+`CONFIRM_CYCLES`.
- The WALK state begins at t0+`CONFIRM_CYCLES`+1.
- `token_clear` is combinational, coincident with the sampled return or timeout; it is never high outside WALK.
- `report_vld` rises the cycle after `token_clear`.
- The ack-to-IDLE transition takes 1 cycle. A new detection can be sampled in the first IDLE cycle.
- WALK lasts between 1 and `WALK_TIMEOUT` cycles.

## Test plan
- **Confirm and walk (happy path).**
  - Stimulus: `PROC_NUM`=4, `dl_detect_vec`=0b0100 held for 8 cycles from t0; `token_active_vec`=0b1000, then 0b0010; `dl_detect_vec[2]` returns high on WALK cycle 3.
  - Required: `origin_vec`=0b0100 at t0+8 only; `token_clear` pulses once; `report_origin_id`=2, `report_proc_mask`=0b1110, `report_len`=3, `report_timeout`=0.
- **Glitch filter.**
  - Stimulus: `dl_detect_vec`=0b0001 held for 7 cycles, then 0.
  - Required: returns to IDLE; `origin_vec` never asserts; `dl_detect_in` stays 0.
- **Priority.**
  - Stimulus: `dl_detect_vec`=0b1010 held.
  - Required: `cand`=1; `origin_vec`=0b0010.
- **Timeout.**
  - Stimulus: `WALK_TIMEOUT`=64; token never returns.
  - Required: `token_clear` on WALK cycle 64 (`wcnt`=63); `report_timeout`=1; mask = origin bit plus any active bits seen.
- **Ack handling.**
  - Stimulus: hold `report_ack`=0 for 20 cycles in REPORT, then pulse it.
  - Required: all report fields stable throughout; `report_vld` and `dl_detect_in` go low 1 cycle after the ack; `report_ack` pulsed during WALK has no effect.
- **Reset mid-walk.**
  - Stimulus: drive `reset`=0 for 1 cycle in WALK.
  - Required: next cycle all outputs are 0 and the state is IDLE; `token_clear` is 0 during reset.
